// File: rtl/fifo_word_packer.sv
// Drains narrow words from a synchronous FIFO read port and packs PACK_RATIO of them
// into one wide beat on a valid/ready stream; flush forces out a partial beat.
module fifo_word_packer #(
    parameter int unsigned  DATA_WIDTH = 32,
    parameter int unsigned  PACK_RATIO = 4,
    localparam int unsigned CNT_W      = $clog2(PACK_RATIO + 1),
    localparam int unsigned BEAT_W     = DATA_WIDTH * PACK_RATIO
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    input  logic                  flush,
    output logic [BEAT_W-1:0]     m_data,
    output logic [CNT_W-1:0]      m_words,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy
);

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                               r_state;
    state_t                               w_next_state;
    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] r_slots;
    logic [CNT_W-1:0]                     r_fill;
    logic                                 r_rd_pend;
    logic [BEAT_W-1:0]                    r_m_data;
    logic [CNT_W-1:0]                     r_m_words;
    logic                                 r_m_valid;

    logic                                 w_rd_allow;
    logic                                 w_flush_pend;
    logic                                 w_emit_rdy;
    logic                                 w_xfer;
    logic                                 w_flush_take;
    logic [CNT_W:0]                       w_occ;
    logic [BEAT_W-1:0]                    w_beat;

    // Words already held plus the one in flight; caps reads at one beat's worth.
    assign w_occ      = {1'b0, r_fill} + (CNT_W + 1)'(r_rd_pend);
    assign w_emit_rdy = (r_fill == CNT_W'(PACK_RATIO)) ||
                        (w_flush_pend && !r_rd_pend && (r_fill != '0));
    assign w_xfer     = w_emit_rdy && (!r_m_valid || m_ready);
    // A flush coinciding with a full-beat transfer leaves nothing to flush for that beat.
    assign w_flush_take = flush && !w_xfer && ((r_fill != '0) || r_rd_pend);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FILL:  if (w_flush_take) w_next_state = ST_FLUSH;
            ST_FLUSH: if (w_xfer)       w_next_state = ST_FILL;
            default:                    w_next_state = ST_FILL;
        endcase
    end

    // State-decoded outputs; the read request must never assert on an empty FIFO.
    always_comb begin
        w_rd_allow   = 1'b0;
        w_flush_pend = 1'b0;
        case (r_state)
            ST_FILL:  w_rd_allow   = 1'b1;
            ST_FLUSH: w_flush_pend = 1'b1;
            default:  w_rd_allow   = 1'b0;
        endcase
        fifo_r_en = !fifo_empty && !rst && w_rd_allow &&
                    (w_occ < (CNT_W + 1)'(PACK_RATIO));
    end

    // Beat image with lanes beyond the fill count zeroed
    always_comb begin
        w_beat = '0;
        for (int k = 0; k < int'(PACK_RATIO); k++) begin
            if (CNT_W'(k) < r_fill) begin
                w_beat[k*DATA_WIDTH +: DATA_WIDTH] = r_slots[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slots   <= '0;
            r_fill    <= '0;
            r_rd_pend <= 1'b0;
            r_m_data  <= '0;
            r_m_words <= '0;
            r_m_valid <= 1'b0;
        end else begin
            r_rd_pend <= fifo_r_en;
            // A transfer only happens with no read landing, so the two never collide.
            if (w_xfer) begin
                r_fill <= '0;
            end else if (r_rd_pend) begin
                r_fill <= r_fill + CNT_W'(1);
            end
            for (int k = 0; k < int'(PACK_RATIO); k++) begin
                if (r_rd_pend && (r_fill == CNT_W'(k))) begin
                    r_slots[k] <= fifo_data;
                end
            end
            if (w_xfer) begin
                r_m_data  <= w_beat;
                r_m_words <= r_fill;
                r_m_valid <= 1'b1;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_data  = r_m_data;
    assign m_words = r_m_words;
    assign m_valid = r_m_valid;
    assign busy    = (r_fill != '0) || r_rd_pend || w_flush_pend || r_m_valid;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: a queue-backed FIFO model with 1-cycle read
// latency feeds the packer, accepted beats are logged and checked against hand values.
module tb_fifo_word_packer;

    localparam int unsigned DW = 32;
    localparam int unsigned PR = 4;
    localparam int unsigned CW = $clog2(PR + 1);
    localparam int unsigned BW = DW * PR;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data  = '0;
    logic          fifo_r_en;
    logic          flush;
    logic [BW-1:0] m_data;
    logic [CW-1:0] m_words;
    logic          m_valid;
    logic          m_ready;
    logic          busy;

    logic [DW-1:0] fifo_q[$];
    logic [BW-1:0] beat_data[$];
    logic [CW-1:0] beat_words[$];
    int            rd_cnt    = 0;
    logic          underflow = 1'b0;

    int checks = 0;
    int errors = 0;

    fifo_word_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_r_en (fifo_r_en),
        .flush     (flush),
        .m_data    (m_data),
        .m_words   (m_words),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // FIFO model: registered empty flag, data valid one cycle after a granted read
    always @(posedge clk) begin
        if (fifo_r_en) begin
            rd_cnt = rd_cnt + 1;
            if (fifo_q.size() == 0) begin
                underflow <= 1'b1;
            end else begin
                fifo_data <= fifo_q.pop_front();
            end
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Beat log
    always @(posedge clk) begin
        if (m_valid && m_ready) begin
            beat_data.push_back(m_data);
            beat_words.push_back(m_words);
        end
    end

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int i = 0; i < budget && beat_data.size() < n; i++) @(negedge clk);
    endtask

    function automatic logic [BW-1:0] beat_at(input int idx);
        return (idx < beat_data.size()) ? beat_data[idx] : {BW{1'bx}};
    endfunction

    function automatic logic [BW-1:0] words_at(input int idx);
        return (idx < beat_words.size()) ? BW'(beat_words[idx]) : {BW{1'bx}};
    endfunction

    task automatic push_seq(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + DW'(i));
    endtask

    initial begin
        int            base_b;
        int            base_rd;
        int            bad;
        int            unstable;
        logic          captured;
        logic [BW-1:0] cap;
        logic [BW-1:0] exp;

        rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_r_en",    BW'(fifo_r_en), BW'(0));
        check("rst_m_valid", BW'(m_valid),   BW'(0));
        check("rst_m_data",  m_data,         BW'(0));
        check("rst_m_words", BW'(m_words),   BW'(0));
        check("rst_busy",    BW'(busy),      BW'(0));
        rst = 1'b0;

        // Full packing
        m_ready = 1'b1;
        base_b  = beat_data.size();
        base_rd = rd_cnt;
        fifo_q.push_back(32'h11); fifo_q.push_back(32'h22);
        fifo_q.push_back(32'h33); fifo_q.push_back(32'h44);
        wait_beats(base_b + 1, 50);
        repeat (5) @(negedge clk);
        check("full_count", BW'(beat_data.size() - base_b), BW'(1));
        check("full_data",  beat_at(base_b), {32'h44, 32'h33, 32'h22, 32'h11});
        check("full_words", words_at(base_b), BW'(4));
        check("full_reads", BW'(rd_cnt - base_rd), BW'(4));

        // Empty guard
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_r_en !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("empty_guard", BW'(bad), BW'(0));

        // Flush partial while the second read is in flight
        base_b  = beat_data.size();
        base_rd = rd_cnt;
        fifo_q.push_back(32'hA); fifo_q.push_back(32'hB);
        for (int i = 0; i < 20 && rd_cnt - base_rd < 2; i++) @(negedge clk);
        check("flush_busy", BW'(busy), BW'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_beats(base_b + 1, 30);
        repeat (5) @(negedge clk);
        check("flush_count", BW'(beat_data.size() - base_b), BW'(1));
        check("flush_data",  beat_at(base_b), {32'h0, 32'h0, 32'hB, 32'hA});
        check("flush_words", words_at(base_b), BW'(2));

        // Backpressure
        m_ready  = 1'b0;
        base_b   = beat_data.size();
        captured = 1'b0;
        unstable = 0;
        cap      = '0;
        push_seq(32'h100, 12);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (m_valid && !captured) begin
                cap = m_data; captured = 1'b1;
            end else if (captured && m_data !== cap) begin
                unstable++;
            end
        end
        check("bp_held",    BW'(captured), BW'(1));
        check("bp_stable",  BW'(unstable), BW'(0));
        check("bp_r_en",    BW'(fifo_r_en), BW'(0));
        check("bp_left",    BW'(fifo_q.size()), BW'(4));
        check("bp_no_beat", BW'(beat_data.size() - base_b), BW'(0));
        m_ready = 1'b1;
        wait_beats(base_b + 3, 60);
        repeat (5) @(negedge clk);
        check("bp_count", BW'(beat_data.size() - base_b), BW'(3));
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < int'(PR); k++) exp[k*DW +: DW] = 32'h100 + DW'(4 * j + k);
            check("bp_data", beat_at(base_b + j), exp);
        end

        // Idle flush produces nothing
        base_b = beat_data.size();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_flush_count", BW'(beat_data.size() - base_b), BW'(0));
        check("idle_flush_busy",  BW'(busy), BW'(0));

        // Reset mid-beat with three words buffered
        push_seq(32'h501, 3);
        repeat (10) @(negedge clk);
        check("pre_rst_busy", BW'(busy), BW'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_valid", BW'(m_valid), BW'(0));
        check("post_rst_busy",  BW'(busy),    BW'(0));
        push_seq(32'h601, 4);
        wait_beats(base_b + 1, 40);
        repeat (5) @(negedge clk);
        check("post_rst_count", BW'(beat_data.size() - base_b), BW'(1));
        check("post_rst_data",  beat_at(base_b), {32'h604, 32'h603, 32'h602, 32'h601});

        // Streaming with random backpressure
        base_b = beat_data.size();
        push_seq(32'h1000, 64);
        for (int i = 0; i < 3000 && beat_data.size() < base_b + 16; i++) begin
            @(negedge clk);
            m_ready = 1'($urandom_range(0, 1));
        end
        m_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("stream_count", BW'(beat_data.size() - base_b), BW'(16));
        for (int j = 0; j < 16; j++) begin
            for (int k = 0; k < int'(PR); k++) exp[k*DW +: DW] = 32'h1000 + DW'(4 * j + k);
            check("stream_data", beat_at(base_b + j), exp);
        end
        check("stream_drained", BW'(fifo_q.size()), BW'(0));
        check("no_underflow",   BW'(underflow), BW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
